// File: rtl/mac_pipe.sv
// mac_pipe: pipelined signed multiply-accumulate over first/last-delimited
// packets. S1 registers operands, S2 the full-width product, S3 folds the
// product into the accumulator, and the output register captures the packet
// total one edge later. One global advance signal freezes every stage when
// a result is held waiting on the output side.
module mac_pipe #(
    parameter int DW     = 9,
    parameter int AW     = 24,
    parameter int CW     = 16,
    parameter int SAT_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_a,
    input  logic signed [DW-1:0] in_b,
    input  logic                 in_first,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [AW-1:0] out_data,
    output logic                 out_ovf,
    output logic [CW-1:0]        out_cnt
);

    localparam int PW     = 2 * DW;
    localparam int STAGES = 3;
    localparam logic [AW-1:0] SAT_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] SAT_MIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          first;
        logic          last;
    } s1_t;

    typedef struct packed {
        logic [PW-1:0] prod;
        logic          first;
        logic          last;
    } s2_t;

    logic               w_advance;
    logic               w_accept;
    logic [STAGES:1]    r_vld_pipe;
    s1_t                r_s1;
    s2_t                r_s2;

    logic [PW-1:0]      w_a_x;
    logic [PW-1:0]      w_b_x;
    logic [PW-1:0]      w_prod;

    logic               w_start;
    logic [AW:0]        w_prod_x;
    logic [AW:0]        w_acc_x;
    logic [AW:0]        w_sum;
    logic               w_sum_ovf;
    logic [AW-1:0]      w_acc_nxt;
    logic [CW-1:0]      w_cnt_nxt;
    logic               w_ovf_nxt;

    logic [AW-1:0]      r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_ovf;
    logic               r_open;
    logic               r_s3_last;

    logic               r_out_valid;
    logic [AW-1:0]      r_out_data;
    logic               r_out_ovf;
    logic [CW-1:0]      r_out_cnt;

    // Everything moves together; only a held, unaccepted result blocks it.
    assign w_advance = !(r_out_valid && !out_ready);
    assign in_ready  = w_advance && !rst;
    assign w_accept  = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign out_data  = $signed(r_out_data);
    assign out_ovf   = r_out_ovf;
    assign out_cnt   = r_out_cnt;

    // Valid shift register: bit k marks stage Sk holding a live beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
        end else if (w_advance) begin
            r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_accept};
        end
    end

    // S1: capture operands and packet markers of an accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= '0;
        end else if (w_advance && w_accept) begin
            r_s1 <= '{a: in_a, b: in_b, first: in_first, last: in_last};
        end
    end

    // Sign-extend both operands to product width; the low PW bits of the
    // product of the extended values equal the exact signed product.
    assign w_a_x  = {{DW{r_s1.a[DW-1]}}, r_s1.a};
    assign w_b_x  = {{DW{r_s1.b[DW-1]}}, r_s1.b};
    assign w_prod = w_a_x * w_b_x;

    // S2: register the full-width product alongside the markers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2 <= '0;
        end else if (w_advance) begin
            r_s2 <= '{prod: w_prod, first: r_s1.first, last: r_s1.last};
        end
    end

    // S3 arithmetic: one guard bit above AW exposes any overflow, since a
    // single product added to an in-range accumulator cannot escape AW+1 bits.
    assign w_start   = r_s2.first || !r_open;
    assign w_prod_x  = {{(AW+1-PW){r_s2.prod[PW-1]}}, r_s2.prod};
    assign w_acc_x   = {r_acc[AW-1], r_acc};
    assign w_sum     = w_start ? w_prod_x : (w_acc_x + w_prod_x);
    assign w_sum_ovf = w_sum[AW] ^ w_sum[AW-1];

    // Clamp toward the true sign (guard bit) or keep the wrapped low bits.
    always_comb begin
        w_acc_nxt = w_sum[AW-1:0];
        if (w_sum_ovf && (SAT_EN != 0)) begin
            w_acc_nxt = w_sum[AW] ? SAT_MIN : SAT_MAX;
        end
    end

    assign w_cnt_nxt = w_start ? CNT_ONE : ((&r_cnt) ? r_cnt : r_cnt + CNT_ONE);
    assign w_ovf_nxt = (w_start ? 1'b0 : r_ovf) | w_sum_ovf;

    // S3: fold a live beat into the running packet state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_open    <= 1'b0;
            r_s3_last <= 1'b0;
        end else if (w_advance) begin
            r_s3_last <= r_vld_pipe[2] && r_s2.last;
            if (r_vld_pipe[2]) begin
                r_acc  <= w_acc_nxt;
                r_cnt  <= w_cnt_nxt;
                r_ovf  <= w_ovf_nxt;
                r_open <= !r_s2.last;
            end
        end
    end

    // Output register: load a finished packet (even on the handshake edge,
    // giving back-to-back results), otherwise drop valid once taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
            r_out_cnt   <= '0;
        end else if (w_advance && r_vld_pipe[3] && r_s3_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_acc;
            r_out_ovf   <= r_ovf;
            r_out_cnt   <= r_cnt;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/mac_pipe.md
Name: mac_pipe

Overview:
- Parametrised, pipelined signed multiply-accumulate unit. It is the successor to the single-product `mul` block.
- Accepts a stream of signed operand pairs over a valid/ready handshake. It accumulates their products between a first marker and a last marker, then emits one accumulated result per packet.
- It supports saturating or wrapping accumulation, a sticky overflow flag, and a beat count.
- It sits on the datapath as the dot-product primitive for fully-connected and convolution layers.

Parameters:
- DW, 9, operand width; signed two's complement.
- AW, 24, accumulator/result width; must satisfy AW >= 2*DW.
- CW, 16, beat-counter width.
- SAT_EN, 1: 1 = saturate the accumulator on overflow; 0 = wrap modulo 2^AW.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- in_a  input  DW  signed operand A.
- in_b  input  DW  signed operand B.
- in_first  input  1  beat starts a new packet.
- in_last  input  1  beat ends the packet; its result is emitted.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  AW  signed accumulated result.
- out_ovf  output  1  at least one overflow occurred during the packet.
- out_cnt  output  CW  number of beats in the packet; saturates at 2^CW-1.

Behaviour:
- Reset (rst=1 at an edge): all pipeline valid bits = 0, accumulator = 0, out_valid = 0, out_data = 0, out_ovf = 0, out_cnt = 0, packet-open flag = 0.
  - Reset overrides any operation in flight; partial packets are discarded.
  - in_ready = 0 during the reset cycle.
- Pipeline and stall:
  - S1 registers the operands and flags. S2 registers the full 2*DW signed product. S3 updates the accumulator and, on last, the output register.
  - Global advance = !(out_valid && !out_ready). in_ready = advance && !rst.
  - A beat is accepted when in_valid && in_ready. All stages shift only on advance; bubbles (valid=0) propagate without touching the accumulator.
- Latency: a last beat accepted at edge N gives out_valid=1 after edge N+3 when there is no stall. Throughput is 1 beat/clock.
- Accumulation at S3, with the product sign-extended to AW+1 bits:
  - Start flag = in_first OR packet-open==0. A beat without in_first after a completed packet starts a new packet.
  - If start: sum = product, cnt = 1, ovf = 0. Otherwise: sum = acc + product, cnt = cnt+1 (saturating at 2^CW-1).
  - Overflow = sum outside [-2^(AW-1), 2^(AW-1)-1].
    - SAT_EN=1: clamp to the nearest bound.
    - SAT_EN=0: keep the low AW bits.
    - In both modes the overflow is ORed into sticky ovf.
  - in_first on a beat while a packet is open discards the old partial result; that result is not emitted.
- Last beat at S3:
  - out_data, out_ovf, out_cnt are loaded from the new accumulator, count and flag; out_valid=1; packet-open=0.
  - in_first && in_last on the same beat produces a single-product result with cnt=1.
- Output handshake:
  - out_valid stays high and out_data/out_ovf/out_cnt stay stable until out_valid && out_ready.
  - Handshake and clear: at the handshake edge out_valid clears unless a new last reaches S3 on the same edge, in which case out_valid remains 1 with the new data (back-to-back results).
  - While stalled, in_ready=0 and nothing advances.

Test Plan:
- Single beat, DW=9 AW=24: (2,6) with first+last → out_data=12, out_cnt=1, out_ovf=0, out_valid 3 clocks after accept.
- Packet (100,100), (-10,10), (-100,-100), first on beat 1, last on beat 3, consecutive cycles → out_data=19900, out_cnt=3, out_ovf=0.
- SAT_EN=1: 128 beats of (-256,-256), i.e. 65536 each, total 8388608 → out_data=8388607, out_ovf=1, out_cnt=128. Same stimulus with SAT_EN=0 → out_data=-8388608, out_ovf=1.
- Backpressure: hold out_ready=0 with a result pending → in_ready=0, outputs stable for 10 cycles. Release → exactly one handshake, pipeline resumes, next packet result is correct.
- Back-to-back single-beat packets (1,1), (2,2), (3,3) with out_ready=1 → results 1, 4, 9 on consecutive cycles.
- Reset mid-packet after 2 beats of (5,5), then packet (3,4) first+last → only 12 is emitted; no result from the aborted packet.
